// File: rtl/id_stage.sv
// Decode stage: control decode, immediate generation, 32x32 register file with
// write-through bypass, load-use hazard detection and a saturating stall counter.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        beq_instruction,
  output logic        aluSrc,
  output logic [1:0]  aluOp,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imediato,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [15:0] stall_count
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [31:0] r_regs [32];
  logic [15:0] r_stall_count;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [7:0]  w_ctrl;
  logic [31:0] w_imm;
  logic        w_uses_rs2;
  logic        w_wb_en;
  logic        w_hazard;
  logic        w_bubble;
  logic        w_unused_funct3;

  assign w_opcode        = instr[6:0];
  assign w_rs1           = instr[19:15];
  assign w_rs2           = instr[24:20];
  assign w_unused_funct3 = ^instr[14:12];

  // Control vector order: reg_write, mem_to_reg, mem_read, mem_write, beq, aluSrc, aluOp[1:0]
  always_comb begin
    w_ctrl     = 8'b0000_0000;
    w_imm      = 32'h0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_ctrl     = 8'b1000_0010;
        w_uses_rs2 = 1'b1;
      end
      OP_I: begin
        w_ctrl = 8'b1000_0111;
        w_imm  = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LW: begin
        w_ctrl = 8'b1110_0100;
        w_imm  = {{20{instr[31]}}, instr[31:20]};
      end
      OP_SW: begin
        w_ctrl     = 8'b0001_0100;
        w_imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl     = 8'b0000_1001;
        w_imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == w_rs1) || (w_uses_rs2 && (ex_rd == w_rs2)));
  assign w_bubble = w_hazard || flush;

  assign {reg_write, mem_to_reg, mem_read, mem_write, beq_instruction, aluSrc, aluOp} =
         w_bubble ? 8'b0 : w_ctrl;

  // A flush squashes the stalled instruction anyway, so the front end keeps moving.
  assign pc_write    = flush || !w_hazard;
  assign if_id_write = flush || !w_hazard;

  assign rs1      = w_rs1;
  assign rs2      = w_rs2;
  assign rd       = instr[11:7];
  assign imediato = w_imm;

  assign w_wb_en = wb_reg_write && (wb_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else if (w_wb_en) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Reset masks the read path so in-flight write-back data cannot leak through the bypass.
  assign rs1_data = (reset || w_rs1 == 5'd0)      ? 32'h0 :
                    (w_wb_en && wb_rd == w_rs1)   ? wb_data : r_regs[w_rs1];
  assign rs2_data = (reset || w_rs2 == 5'd0)      ? 32'h0 :
                    (w_wb_en && wb_rd == w_rs2)   ? wb_data : r_regs[w_rs2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 16'h0;
    end else if (w_hazard && !flush && r_stall_count != 16'hFFFF) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a table-driven reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_to_reg, reg_write, mem_read, mem_write, beq_instruction, aluSrc;
  logic [1:0]  aluOp;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imediato, rs1_data, rs2_data;
  logic        pc_write, if_id_write;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  int          m_stall;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .beq_instruction(beq_instruction), .aluSrc(aluSrc),
    .aluOp(aluOp), .rs1(rs1), .rs2(rs2), .rd(rd), .imediato(imediato),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc_write(pc_write),
    .if_id_write(if_id_write), .stall_count(stall_count)
  );

  function automatic logic [31:0] r_type(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [11:0] imm);
    return {imm, s1, 3'b000, d, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] imm);
    return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] imm);
    return {imm[12], imm[10:5], s2, s1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Spec decode table: {reg_write, mem_to_reg, mem_read, mem_write, beq, aluSrc, aluOp}
  function automatic logic [7:0] spec_ctrl(input logic [6:0] op);
    case (op)
      7'b0110011: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
      7'b0010011: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
      7'b0000011: return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
      7'b0100011: return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
      7'b1100011: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] spec_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'b0010011, 7'b0000011: v = int'($signed(ins[31:20]));
      7'b0100011: begin
        logic [11:0] s;
        s = {ins[31:25], ins[11:7]};
        v = int'($signed(s));
      end
      7'b1100011: begin
        logic [12:0] b;
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        v = int'($signed(b));
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit model_hazard();
    bit rs2_used;
    rs2_used = (instr[6:0] == 7'b0110011) || (instr[6:0] == 7'b0100011) || (instr[6:0] == 7'b1100011);
    return ex_mem_read && ex_rd != 0 &&
           (ex_rd == instr[19:15] || (rs2_used && ex_rd == instr[24:20]));
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (reset || a == 0) return 32'h0;
    if (wb_reg_write && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit hz;
    logic [7:0] ec;
    hz = model_hazard();
    ec = (hz || flush) ? 8'h00 : spec_ctrl(instr[6:0]);
    chk({tag, ".ctrl"}, 32'({reg_write, mem_to_reg, mem_read, mem_write, beq_instruction, aluSrc, aluOp}), 32'(ec));
    chk({tag, ".regs"}, 32'({rs1, rs2, rd}), 32'({instr[19:15], instr[24:20], instr[11:7]}));
    chk({tag, ".imm"}, imediato, spec_imm(instr));
    chk({tag, ".rs1_data"}, rs1_data, model_read(instr[19:15]));
    chk({tag, ".rs2_data"}, rs2_data, model_read(instr[24:20]));
    chk({tag, ".stall_en"}, 32'({pc_write, if_id_write}), (flush || !hz) ? 32'd3 : 32'd0);
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
  endtask

  // Inputs are already applied; check, then let one rising edge happen and update the model.
  task automatic step(input string tag);
    bit hz;
    #1;
    check_all(tag);
    hz = model_hazard();
    @(posedge clk);
    if (!reset) begin
      if (wb_reg_write && wb_rd != 0) m_regs[wb_rd] = wb_data;
      if (hz && !flush && m_stall < 65535) m_stall++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    instr = 32'h0; flush = 0; ex_mem_read = 0; ex_rd = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_stall = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();

    // Reset: writes ignored, reads zero.
    wb_reg_write = 1; wb_rd = 5'd9; wb_data = 32'hCAFE0001;
    instr = r_type(5'd1, 5'd9, 5'd9);
    @(negedge clk);
    step("reset_hold");
    chk("reset_rs1_zero", rs1_data, 32'h0);
    reset = 1'b0;
    idle_inputs();
    step("post_reset_idle");
    instr = r_type(5'd1, 5'd9, 5'd0);
    step("x9_not_written");

    // Write x5 then read via add x1,x5,x0.
    wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; instr = 32'h0;
    step("wr_x5");
    idle_inputs();
    instr = r_type(5'd1, 5'd5, 5'd0);
    #1;
    chk("add_rs1_data", rs1_data, 32'hDEADBEEF);
    chk("add_rs2_data", rs2_data, 32'h0);
    chk("add_ctrl", 32'({reg_write, mem_to_reg, mem_read, mem_write, beq_instruction, aluSrc, aluOp}), 32'h82);
    step("add_x1_x5_x0");

    // x0 is never written.
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h1234; instr = r_type(5'd2, 5'd0, 5'd0);
    step("wr_x0");
    idle_inputs();
    instr = r_type(5'd2, 5'd0, 5'd0);
    #1;
    chk("x0_reads_zero", rs1_data, 32'h0);
    step("rd_x0");

    // Same-cycle write-through bypass.
    wb_reg_write = 1; wb_rd = 5'd7; wb_data = 32'h55; instr = r_type(5'd3, 5'd1, 5'd7);
    #1;
    chk("bypass_rs2", rs2_data, 32'h55);
    step("bypass");
    idle_inputs();

    // Load-use stall for three cycles.
    ex_mem_read = 1; ex_rd = 5'd3; instr = r_type(5'd4, 5'd3, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc_write", 32'({pc_write, if_id_write}), 32'd0);
      step("load_use");
    end
    chk("stall_count_3", 32'(stall_count), 32'd3);
    ex_rd = 5'd0;
    step("ex_rd_zero_no_stall");
    ex_rd = 5'd2; instr = i_type(7'b0010011, 5'd4, 5'd3, 12'h005);
    step("rs2_ignored_for_i");

    // Flush beats hazard; stall_count holds.
    ex_rd = 5'd3; instr = r_type(5'd4, 5'd3, 5'd2); flush = 1;
    #1;
    chk("flush_pc_write", 32'({pc_write, if_id_write}), 32'd3);
    step("flush_hazard");
    chk("flush_count_held", 32'(stall_count), 32'd3);
    idle_inputs();
    instr = b_type(5'd1, 5'd2, 13'h1FF8);
    #1;
    chk("beq_imm_m8", imediato, 32'hFFFFFFF8);
    step("beq_m8");
    instr = s_type(5'd5, 5'd6, 12'h80C);
    step("sw_neg");
    instr = i_type(7'b0000011, 5'd8, 5'd5, 12'h7FF);
    step("lw_pos");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops [6];
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
      ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'($urandom);
      instr = {$urandom} & 32'hFFFF_FF80;
      instr[6:0] = ops[$urandom_range(0, 5)];
      ex_mem_read = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ex_rd = instr[19:15];
        1: ex_rd = instr[24:20];
        default: ex_rd = 5'($urandom);
      endcase
      flush = ($urandom_range(0, 7) == 0);
      wb_reg_write = 1'($urandom);
      wb_rd = ($urandom_range(0, 3) == 0) ? instr[19:15] : 5'($urandom);
      wb_data = $urandom;
      step("rand");
    end

    // Asynchronous reset between edges.
    idle_inputs();
    wb_reg_write = 1; wb_rd = 5'd12; wb_data = 32'hA5A5A5A5;
    step("pre_async_wr");
    idle_inputs();
    ex_mem_read = 1; ex_rd = 5'd12; instr = r_type(5'd1, 5'd12, 5'd5);
    step("pre_async_stall");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rs1_zero", rs1_data, 32'h0);
    chk("async_rs2_zero", rs2_data, 32'h0);
    chk("async_stall_zero", 32'(stall_count), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    wb_reg_write = 1; wb_rd = 5'd12; wb_data = 32'h0BADF00D;
    step("first_wr_after_reset");
    idle_inputs();
    instr = r_type(5'd1, 5'd12, 5'd5);
    #1;
    chk("first_wr_seen", rs1_data, 32'h0BADF00D);
    step("post_reset_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  rising-edge clock for register file and counters.
REQ-002 reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
REQ-003 instr  input  32  instruction from IF/ID register.
REQ-004 flush  input  1  taken-branch flush from EX; forces bubble.
REQ-005 ex_mem_read, ex_rd  input  1, 5  mem_read_out / rd_out currently held in ID/EX register (hazard check).
REQ-006 wb_reg_write, wb_rd, wb_data  input  1, 5, 32  write-back port from MEM/WB.
REQ-007 mem_to_reg, reg_write, mem_read, mem_write, beq_instruction, aluSrc  output  1 each  control to ID/EX.
REQ-008 aluOp  output  2  ALU op class to ID/EX.
REQ-009 rs1, rs2, rd  output  5 each  instr[19:15], instr[24:20], instr[11:7].
REQ-010 imediato  output  32  sign-extended immediate.
REQ-011 rs1_data, rs2_data  output  32 each  register-file read data.
REQ-012 pc_write, if_id_write  output  1 each  enable for PC and IF/ID; low = stall.
REQ-013 stall_count  output  16  number of load-use stall cycles since reset.

Function
REQ-014 Decode by opcode instr[6:0] SHALL produce controls {reg_write, mem_to_reg, mem_read, mem_write, beq_instruction, aluSrc, aluOp}: 0110011 R -> 1,0,0,0,0,0,10; 0010011 I-ALU -> 1,0,0,0,0,1,11; 0000011 lw -> 1,1,1,0,0,1,00; 0100011 sw -> 0,0,0,1,0,1,00; 1100011 beq -> 0,0,0,0,1,0,01; any other opcode -> all 0.
REQ-015 Immediate: I-type/lw SHALL be sext(instr[31:20]); sw sext({instr[31:25],instr[11:7]}); beq sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); R-type/unknown 0.
REQ-016 Register file: 32 x 32-bit; x0 SHALL always read 0 and never be written.
REQ-017 Write SHALL occur on rising clk when wb_reg_write=1 and wb_rd!=0.
REQ-018 Reads combinational; if wb_reg_write=1, wb_rd!=0 and wb_rd equals read address, read SHALL return wb_data same cycle (write-through bypass).
REQ-019 Load-use hazard SHALL be asserted when ex_mem_read=1, ex_rd!=0 and (ex_rd==rs1, or ex_rd==rs2 for R, sw, beq opcodes).
REQ-020 On hazard: pc_write=0, if_id_write=0, all control outputs forced 0 (bubble); rs/rd/imediato/data still driven from instr.
REQ-021 Without hazard pc_write=if_id_write=1.
REQ-022 flush=1 SHALL force all control outputs 0 and SHALL NOT deassert pc_write/if_id_write; flush has priority over hazard for stall outputs (both 1 when flush=1).
REQ-023 stall_count SHALL increment on each rising clk where hazard=1 and flush=0; saturates at 16'hFFFF.
REQ-024 All non-register-file outputs combinational from instr, inputs and register-file state; zero internal latency.

Reset
REQ-025 While reset=1: all 32 registers SHALL read 0, stall_count=0, writes ignored.
REQ-026 Reset asserted mid-operation SHALL clear state immediately without waiting for clk; first write accepted on first rising clk after reset falls.
REQ-027 Combinational outputs during reset follow instr with zeroed register data.

Verification
REQ-028 Write x5=32'hDEADBEEF via WB port, then instr add x1,x5,x0 -> rs1_data=DEADBEEF, rs2_data=0, controls 1,0,0,0,0,0,10.
REQ-029 wb_rd=0, wb_data=32'h1234, wb_reg_write=1, then read x0 -> rs1_data=0.
REQ-030 Same-cycle wb_rd=7 wb_data=32'h55 while instr reads rs2=7 -> rs2_data=32'h55 before clock edge.
REQ-031 ex_mem_read=1, ex_rd=3, instr add x4,x3,x2 for 3 cycles -> pc_write=if_id_write=0, controls 0, stall_count=3; ex_rd=0 same case -> no stall.
REQ-032 Hazard plus flush=1 -> controls 0, pc_write=if_id_write=1, stall_count unchanged; beq with offset -8 -> imediato=32'hFFFFFFF8.
REQ-033 Assert reset asynchronously between edges after writes -> all reads 0 and stall_count=0 immediately.
